// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS memory-stage slice.
//   - mem_state_e : memory-access FSM states (IDLE, REQ, DONE)
//   - WB_REGWRITE / WB_MEMTOREG : bit positions inside the 2-bit WB control field
//   - DATA_W_DEF / REG_W_DEF : default data and register-index widths
//   - addr_aligned() : word-alignment check on the low address bits
package mips_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_W_DEF   = 5;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Word accesses only: both low address bits must be clear.
    function automatic logic addr_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with bubble insertion.
//   clk, rst             : clock, asynchronous active-low reset
//   bubble               : 1 = clear WB control this edge and keep data outputs
//   is_load              : the instruction in MEM is a load (selects rdata_in)
//   WB_ctl_in, alu_in, reg_dst_in, rdata_in : values from the memory stage
//   WB_ctl_out, read_data_out, alu_out, reg_dst_out : registered outputs to WB
module mem_wb_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              is_load,
    input  logic [1:0]        WB_ctl_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [REG_W-1:0]  reg_dst_in,
    input  logic [DATA_W-1:0] rdata_in,
    output logic [1:0]        WB_ctl_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_W-1:0]  reg_dst_out
);

    // Pipeline register: a bubble kills only the write-back controls so a
    // stalled or squashed instruction never writes the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_ctl_out    <= 2'b00;
            read_data_out <= '0;
            alu_out       <= '0;
            reg_dst_out   <= '0;
        end else if (bubble) begin
            WB_ctl_out    <= 2'b00;
        end else begin
            WB_ctl_out    <= WB_ctl_in;
            alu_out       <= alu_in;
            reg_dst_out   <= reg_dst_in;
            read_data_out <= is_load ? rdata_in : '0;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MIPS memory-stage controller.
//   Resolves beq/bne, runs a req/ack handshake to a variable-latency data
//   memory, stalls the upstream pipeline during an access and owns the
//   MEM/WB register (mem_wb_reg).
// Ports:
//   clk, rst (async active-low)
//   EX/MEM inputs : WB_ctl_in, MEMRead, MEMWrite, Branch, EQ_NE, eq_in, ne_in,
//                   bran_PC, ALU_result, WD, reg_dst
//   data memory   : dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_ack, dmem_rdata
//   pipeline      : stall, pc_src, pc_target
//   errors        : misalign_err (sticky), timeout_err (sticky)
//   MEM/WB        : WB_ctl_out, read_data_out, alu_out, reg_dst_out
// Build option: define MEM_TIMEOUT_EN to add a REQ watchdog of TIMEOUT cycles
// that aborts the access and sets timeout_err; otherwise REQ waits forever.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        WB_ctl_in,
    input  logic              MEMRead,
    input  logic              MEMWrite,
    input  logic              Branch,
    input  logic              EQ_NE,
    input  logic              eq_in,
    input  logic              ne_in,
    input  logic [DATA_W-1:0] bran_PC,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] WD,
    input  logic [REG_W-1:0]  reg_dst,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target,
    output logic              misalign_err,
    output logic              timeout_err,
    output logic [1:0]        WB_ctl_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_W-1:0]  reg_dst_out
);

    mem_state_e        state_r;
    logic              req_r;
    logic [DATA_W-1:0] rdata_r;
    logic              misalign_r;
    logic              op_s;
    logic              aligned_s;
    logic              stall_s;
    logic              bubble_s;

    assign op_s      = MEMRead | MEMWrite;
    assign aligned_s = addr_aligned(ALU_result[1:0]);

    // Branch resolution is purely combinational and ignores the FSM.
    assign pc_src    = Branch & (EQ_NE ? ne_in : eq_in);
    assign pc_target = bran_PC;

    // The EX/MEM register is frozen while stalled, so its outputs are the
    // request payload for the whole REQ phase.
    assign dmem_req     = req_r;
    assign dmem_we      = MEMWrite;
    assign dmem_addr    = ALU_result;
    assign dmem_wdata   = WD;
    assign misalign_err = misalign_r;
    assign stall        = stall_s;

    // Stall decode: the op is held in IDLE (while the request is launched) and REQ.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE:    stall_s = op_s & aligned_s;
            REQ:     stall_s = 1'b1;
            DONE:    stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // A misaligned op is squashed into a bubble instead of being stalled.
    assign bubble_s = stall_s | ((state_r == IDLE) & op_s & ~aligned_s);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             timeout_r;

    assign timeout_err = timeout_r;

    // Access FSM with watchdog: TIMEOUT REQ cycles without ack abort the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            req_r      <= 1'b0;
            rdata_r    <= '0;
            misalign_r <= 1'b0;
            cnt_r      <= '0;
            timeout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (op_s && aligned_s) begin
                        state_r <= REQ;
                        req_r   <= 1'b1;
                        cnt_r   <= '0;
                    end else if (op_s) begin
                        misalign_r <= 1'b1;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        rdata_r <= dmem_rdata;
                        req_r   <= 1'b0;
                        state_r <= DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        timeout_r <= 1'b1;
                        rdata_r   <= '0;
                        req_r     <= 1'b0;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end
`else
    assign timeout_err = 1'b0;

    // Access FSM: REQ holds until the memory acknowledges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            req_r      <= 1'b0;
            rdata_r    <= '0;
            misalign_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (op_s && aligned_s) begin
                        state_r <= REQ;
                        req_r   <= 1'b1;
                    end else if (op_s) begin
                        misalign_r <= 1'b1;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        rdata_r <= dmem_rdata;
                        req_r   <= 1'b0;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end
`endif

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb (
        .clk           (clk),
        .rst           (rst),
        .bubble        (bubble_s),
        .is_load       (MEMRead),
        .WB_ctl_in     (WB_ctl_in),
        .alu_in        (ALU_result),
        .reg_dst_in    (reg_dst),
        .rdata_in      (rdata_r),
        .WB_ctl_out    (WB_ctl_out),
        .read_data_out (read_data_out),
        .alu_out       (alu_out),
        .reg_dst_out   (reg_dst_out)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: self-checking bench for mem_stage_ctrl.
// Table-driven non-memory vectors, hand-written load/store/misalign/reset
// sequences, and a MEM/WB scoreboard queue. The watchdog sequence is compiled
// only when MEM_TIMEOUT_EN is defined (DUT built with TIMEOUT=4).
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  WB_ctl_in;
    logic        MEMRead, MEMWrite, Branch, EQ_NE, eq_in, ne_in;
    logic [31:0] bran_PC, ALU_result, WD;
    logic [4:0]  reg_dst;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, pc_src, misalign_err, timeout_err;
    logic [31:0] pc_target, read_data_out, alu_out;
    logic [1:0]  WB_ctl_out;
    logic [4:0]  reg_dst_out;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        br, eqne, eq, ne;
        logic [31:0] bpc, alu;
        logic [1:0]  wbc;
        logic [4:0]  rd;
        logic        exp_src;
    } vec_t;

    typedef struct {
        logic [1:0]  wbc;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] rdata;
    } wb_t;

    wb_t sb[$];

    mem_stage_ctrl #(.DATA_W(32), .REG_W(5), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .WB_ctl_in(WB_ctl_in), .MEMRead(MEMRead),
        .MEMWrite(MEMWrite), .Branch(Branch), .EQ_NE(EQ_NE), .eq_in(eq_in),
        .ne_in(ne_in), .bran_PC(bran_PC), .ALU_result(ALU_result), .WD(WD),
        .reg_dst(reg_dst), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall(stall), .pc_src(pc_src),
        .pc_target(pc_target), .misalign_err(misalign_err),
        .timeout_err(timeout_err), .WB_ctl_out(WB_ctl_out),
        .read_data_out(read_data_out), .alu_out(alu_out),
        .reg_dst_out(reg_dst_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_nop();
        MEMRead = 1'b0; MEMWrite = 1'b0; Branch = 1'b0; EQ_NE = 1'b0;
        eq_in = 1'b0; ne_in = 1'b0; WB_ctl_in = 2'b00;
        bran_PC = 32'h0; ALU_result = 32'h0; WD = 32'h0; reg_dst = 5'd0;
    endtask

    // Pop the oldest expectation and compare the MEM/WB outputs with it.
    task automatic compare_wb(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s_sb_empty: got empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_wbctl"}, {30'd0, WB_ctl_out}, {30'd0, e.wbc});
            check({tag, "_alu"},   alu_out, e.alu);
            check({tag, "_rd"},    {27'd0, reg_dst_out}, {27'd0, e.rd});
            check({tag, "_rdata"}, read_data_out, e.rdata);
        end
    endtask

    // Aligned load/store; ack arrives after 'delay' wait cycles in REQ.
    task automatic mem_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [1:0] wbc, input int delay,
                          input logic [31:0] rdata, input string tag);
        int stall_cnt = 0;
        int req_cnt = 0;
        int ack_cnt = 0;
        bit done = 1'b0;
        @(negedge clk);
        drive_nop();
        MEMRead = ~we; MEMWrite = we; ALU_result = addr; WD = wd;
        reg_dst = rd; WB_ctl_in = wbc;
        sb.push_back('{wbc, addr, rd, (we ? 32'h0 : rdata)});
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall) stall_cnt++;
            else begin
                done = 1'b1;
                check({tag, "_bubbled"}, {30'd0, WB_ctl_out}, 32'd0);
            end
            if (dmem_req) begin
                req_cnt++;
                check({tag, "_we"}, {31'd0, dmem_we}, {31'd0, we});
                check({tag, "_addr"}, dmem_addr, addr);
                check({tag, "_wdata"}, dmem_wdata, wd);
                if (req_cnt > delay) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata; ack_cnt++;
                end
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0; dmem_rdata = 32'hA5A5_A5A5;
            if (!done) @(negedge clk);
        end
        check({tag, "_completed"}, {31'd0, done}, 32'd1);
        check({tag, "_stall_cycles"}, stall_cnt, 2 + delay);
        check({tag, "_acks"}, ack_cnt, 1);
        compare_wb(tag);
        drive_nop();
        check({tag, "_req_dropped"}, {31'd0, dmem_req}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_1111, 2'b10, 5'd3,  1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_2222, 2'b10, 5'd4,  1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_00C0, 32'h0000_3333, 2'b00, 5'd5,  1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_4444, 2'b10, 5'd6,  1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 2'b10, 5'd31, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE_0000, 32'h0000_0003, 2'b01, 5'd17, 1'b0};

        rst = 1'b0;
        drive_nop();
        dmem_ack = 1'b0; dmem_rdata = 32'hA5A5_A5A5;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wbctl", {30'd0, WB_ctl_out}, 32'd0);
        check("rst_rdata", read_data_out, 32'd0);
        check("rst_alu", alu_out, 32'd0);
        check("rst_rd", {27'd0, reg_dst_out}, 32'd0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        check("rst_timeout", {31'd0, timeout_err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Non-memory instructions: branch resolution and single-cycle MEM/WB update.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            Branch = vecs[i].br; EQ_NE = vecs[i].eqne; eq_in = vecs[i].eq; ne_in = vecs[i].ne;
            bran_PC = vecs[i].bpc; ALU_result = vecs[i].alu;
            WB_ctl_in = vecs[i].wbc; reg_dst = vecs[i].rd;
            sb.push_back('{vecs[i].wbc, vecs[i].alu, vecs[i].rd, 32'h0});
            #1;
            check($sformatf("vec%0d_pc_src", i), {31'd0, pc_src}, {31'd0, vecs[i].exp_src});
            check($sformatf("vec%0d_pc_target", i), pc_target, vecs[i].bpc);
            check($sformatf("vec%0d_stall", i), {31'd0, stall}, 32'd0);
            check($sformatf("vec%0d_req", i), {31'd0, dmem_req}, 32'd0);
            @(posedge clk); #1;
            compare_wb($sformatf("vec%0d", i));
        end

        mem_op(1'b0, 32'h0000_0100, 32'h0, 5'd9, 2'b11, 0, 32'hDEAD_BEEF, "load0");
        mem_op(1'b1, 32'h0000_0204, 32'h1357_9BDF, 5'd0, 2'b00, 3, 32'h0, "store3");
        check("no_timeout_err", {31'd0, timeout_err}, 32'd0);
        mem_op(1'b0, 32'h0000_0008, 32'h0, 5'd12, 2'b11, 1, 32'h0BAD_CAFE, "load1");

        // Misaligned load: squashed, no request, sticky error.
        @(negedge clk);
        drive_nop();
        MEMRead = 1'b1; ALU_result = 32'h0000_0103; WB_ctl_in = 2'b11; reg_dst = 5'd7;
        #1;
        check("mis_req", {31'd0, dmem_req}, 32'd0);
        check("mis_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        check("mis_err", {31'd0, misalign_err}, 32'd1);
        check("mis_bubble", {30'd0, WB_ctl_out}, 32'd0);
        check("mis_req_after", {31'd0, dmem_req}, 32'd0);
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        check("mis_err_sticky", {31'd0, misalign_err}, 32'd1);

        // Reset in the middle of a REQ drops the request at once.
        @(negedge clk);
        MEMRead = 1'b1; ALU_result = 32'h0000_0300; WB_ctl_in = 2'b11; reg_dst = 5'd2;
        @(posedge clk); #1;
        check("midrst_req_up", {31'd0, dmem_req}, 32'd1);
        #2;
        rst = 1'b0;
        drive_nop();
        #1;
        check("midrst_req", {31'd0, dmem_req}, 32'd0);
        check("midrst_misalign", {31'd0, misalign_err}, 32'd0);
        check("midrst_wbctl", {30'd0, WB_ctl_out}, 32'd0);
        check("midrst_alu", alu_out, 32'd0);
        check("midrst_rdata", read_data_out, 32'd0);
        check("midrst_rd", {27'd0, reg_dst_out}, 32'd0);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_op(1'b0, 32'h0000_0010, 32'h0, 5'd21, 2'b11, 0, 32'h7654_3210, "load_after_rst");

`ifdef MEM_TIMEOUT_EN
        // Watchdog: no ack ever, access aborted after 4 REQ cycles.
        begin
            int scnt = 0;
            int rcnt = 0;
            bit fin = 1'b0;
            @(negedge clk);
            drive_nop();
            MEMRead = 1'b1; ALU_result = 32'h0000_0400; WB_ctl_in = 2'b11; reg_dst = 5'd8;
            sb.push_back('{2'b11, 32'h0000_0400, 5'd8, 32'h0});
            for (int c = 0; c < 40 && !fin; c++) begin
                #1;
                if (stall) scnt++;
                else fin = 1'b1;
                if (dmem_req) rcnt++;
                @(posedge clk); #1;
                if (!fin) @(negedge clk);
            end
            check("to_completed", {31'd0, fin}, 32'd1);
            check("to_req_cycles", rcnt, 4);
            check("to_stall_cycles", scnt, 5);
            check("to_err", {31'd0, timeout_err}, 32'd1);
            compare_wb("to");
            drive_nop();
        end
        mem_op(1'b0, 32'h0000_0020, 32'h0, 5'd11, 2'b11, 0, 32'h1111_2222, "load_after_to");
        check("to_err_sticky", {31'd0, timeout_err}, 32'd1);
`endif

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller for the 5-stage MIPS pipeline, sitting directly downstream of the EX/MEM pipeline register and consuming its outputs. It resolves branches (beq/bne), runs a request/acknowledge handshake to a variable-latency data memory for loads and stores, and stalls the upstream pipeline while an access is outstanding. It also holds the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- DATA_W, 32, data/address width
- REG_W, 5, register-index width
- TIMEOUT, 64, watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- WB_ctl_in  in  2  {RegWrite, MemtoReg} from EX/MEM
- MEMRead, MEMWrite, Branch, EQ_NE  in  1 each  MEM controls from EX/MEM; EQ_NE=0 selects beq, EQ_NE=1 selects bne
- eq_in, ne_in  in  1 each  ALU compare flags
- bran_PC  in  DATA_W  branch target
- ALU_result  in  DATA_W  memory address or ALU value
- WD  in  DATA_W  store data
- reg_dst  in  REG_W  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1=store, 0=load
- dmem_addr, dmem_wdata  out  DATA_W  request address and store data
- dmem_ack  in  1  request accepted and completed this cycle
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- pc_src  out  1  branch taken
- pc_target  out  DATA_W  equals bran_PC
- misalign_err  out  1  sticky, cleared only by reset
- timeout_err  out  1  sticky; tied 0 without MEM_TIMEOUT_EN
- WB_ctl_out  out  2  MEM/WB control
- read_data_out, alu_out  out  DATA_W  MEM/WB data
- reg_dst_out  out  REG_W  MEM/WB destination register

## Operation
- Memory op present: op = MEMRead | MEMWrite. MEMRead and MEMWrite never both 1.
- FSM states:
  - IDLE: if op and ALU_result[1:0]==0, go to REQ; stall=1.
  - REQ: dmem_req=1, with dmem_we/addr/wdata driven from the held EX/MEM values; stall=1. If dmem_ack, capture dmem_rdata into an internal register and go to DONE.
  - DONE: stall=0 for exactly one cycle, then go to IDLE. The same op is not re-issued.
- Misaligned op (ALU_result[1:0]!=0) in IDLE:
  - no request is issued; set misalign_err; stall=0
  - the op is converted to a bubble: WB_ctl_out=0 at the next edge
- pc_src = Branch & (EQ_NE ? ne_in : eq_in). This is combinational and independent of the FSM.
- MEM/WB update at each edge:
  - if stall: WB_ctl_out<=0 (bubble); data outputs hold
  - else: WB_ctl_out<=WB_ctl_in, alu_out<=ALU_result, reg_dst_out<=reg_dst, read_data_out<=captured rdata (load) or 0 (otherwise)

## Timing
- Reset (rst=0, asynchronous): state=IDLE; every registered output is 0; dmem_req=0; both error flags=0.
- Load/store with ack in the first REQ cycle:
  - stall is high for 2 cycles (IDLE, REQ)
  - MEM/WB captures at the end of DONE, the 3rd cycle after the op reaches EX/MEM output
- Each extra wait cycle (ack low in REQ) adds 1 stall cycle.
- Non-memory instructions: 0 stall cycles; MEM/WB captures at the next edge.
- dmem_ack is ignored outside REQ.
- A reset asserted mid-access drops dmem_req asynchronously. The interrupted access is not retried.
- Ops in back-to-back cycles: DONE→IDLE, then the new op is seen in IDLE the following cycle.

## Configuration
- MEM_TIMEOUT_EN defined:
  - an 8-bit-or-wider counter runs in REQ
  - on reaching TIMEOUT without ack: set timeout_err, load rdata=0, go to DONE (access aborted)
  - the counter clears on entry to REQ
- MEM_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; timeout_err=0.

## Structure
- Shared package mips_pkg:
  - FSM state enum (IDLE, REQ, DONE)
  - WB_ctl bit positions (RegWrite=1, MemtoReg=0)
  - DATA_W/REG_W defaults
- One sub-module, mem_wb_reg, holds the MEM/WB register with bubble insertion. The FSM, branch logic and watchdog stay in mem_stage_ctrl.

## Test plan
- Reset: drive rst=0 mid-REQ → all outputs 0 and dmem_req=0 immediately; after release, FSM in IDLE.
- Load from addr 0x100, ack in the first REQ cycle, rdata=0xDEADBEEF → stall high 2 cycles; then read_data_out=0xDEADBEEF, WB_ctl_out=2'b11, reg_dst_out=reg_dst.
- Store to 0x204 with ack delayed 3 cycles → dmem_we=1, dmem_wdata=WD held for the whole REQ; stall high 5 cycles; exactly one request completes.
- Branch=1, EQ_NE=1, ne_in=1, bran_PC=0x40 → pc_src=1, pc_target=0x40 in the same cycle; stall=0.
- Load to address 0x103 → no dmem_req; misalign_err=1 and it stays 1; next WB_ctl_out=0.
- With MEM_TIMEOUT_EN and TIMEOUT=4, ack never asserted → timeout_err=1 after 4 REQ cycles; read_data_out=0; pipeline resumes.
